// File: rtl/switch_frame_sequencer_if.sv
// Bus bundle between the frame sequencer and its environment: run control,
// FIFO read port and the switch-side outputs.
interface switch_frame_sequencer_if #(
  parameter int DATA_WIDTH   = 128,
  parameter int NUM_SWITCHES = 7,
  parameter int SIZE_WIDTH   = 32
);
  logic                    start;
  logic [SIZE_WIDTH-1:0]   frame_count;
  logic                    sync;
  logic [DATA_WIDTH-1:0]   fifo_rd_data;
  logic                    fifo_empty;
  logic                    fifo_rd_en;
  logic [NUM_SWITCHES-1:0] out_to_switches;
  logic                    out_valid;
  logic                    busy;
  logic                    done;
  logic                    underrun;

  // Environment side: drives control and FIFO data, observes the sequencer.
  modport master (
    output start, frame_count, sync, fifo_rd_data, fifo_empty,
    input  fifo_rd_en, out_to_switches, out_valid, busy, done, underrun
  );

  // Sequencer side.
  modport slave (
    input  start, frame_count, sync, fifo_rd_data, fifo_empty,
    output fifo_rd_en, out_to_switches, out_valid, busy, done, underrun
  );
endinterface

// File: rtl/switch_frame_sequencer.sv
// Pops plaintext bitmap words from a FIFO, slices each word into
// NUM_SWITCHES-bit frames (LSB first) and presents one frame per sync strobe
// until the programmed frame count is used up. A one-word prefetch buffer
// (nxt) keeps the current word (cur) refilled so sync can run every cycle.
module switch_frame_sequencer #(
  parameter int DATA_WIDTH   = 128,
  parameter int NUM_SWITCHES = 7,
  parameter int SIZE_WIDTH   = 32
) (
  input logic clock,
  input logic reset,
  switch_frame_sequencer_if.slave bus
);
  localparam int FPW   = DATA_WIDTH / NUM_SWITCHES;
  localparam int IDX_W = (FPW > 1) ? $clog2(FPW) : 1;
  localparam int CW    = SIZE_WIDTH + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FPW - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state;
  state_t state_next;

  logic [SIZE_WIDTH-1:0]   frames_left;
  logic [SIZE_WIDTH-1:0]   words_left;
  logic [SIZE_WIDTH-1:0]   words_total;
  logic [DATA_WIDTH-1:0]   cur_word;
  logic [DATA_WIDTH-1:0]   nxt_word;
  logic                    cur_valid;
  logic                    nxt_valid;
  logic [IDX_W-1:0]        idx;
  logic                    rd_valid;
  logic                    rd_en_q;
  logic [NUM_SWITCHES-1:0] out_q;
  logic                    out_valid_q;
  logic                    done_q;
  logic                    underrun_q;
  logic [NUM_SWITCHES-1:0] frame_slice;

  logic accept_start;
  logic zero_start;
  logic accept_sync;
  logic miss_sync;
  logic release_cur;
  logic last_frame;
  logic issue;

  assign words_total = SIZE_WIDTH'(({1'b0, bus.frame_count} + CW'(FPW - 1)) / CW'(FPW));
  assign frame_slice = NUM_SWITCHES'(cur_word >> (int'(idx) * NUM_SWITCHES));

  assign bus.fifo_rd_en      = rd_en_q;
  assign bus.out_to_switches = out_q;
  assign bus.out_valid       = out_valid_q;
  assign bus.done            = done_q;
  assign bus.underrun        = underrun_q;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state: a non-zero start enters RUN, the last frame returns to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.start && (bus.frame_count != '0)) state_next = RUN;
      RUN:  if (last_frame) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control strobes: start/sync acceptance, word release and FIFO pop issue.
  always_comb begin
    accept_start = 1'b0;
    zero_start   = 1'b0;
    accept_sync  = 1'b0;
    miss_sync    = 1'b0;
    release_cur  = 1'b0;
    last_frame   = 1'b0;
    issue        = 1'b0;
    bus.busy     = (state == RUN);
    case (state)
      IDLE: begin
        accept_start = bus.start;
        zero_start   = bus.start && (bus.frame_count == '0);
        issue        = bus.start && (bus.frame_count != '0) && !bus.fifo_empty;
      end
      RUN: begin
        accept_sync = bus.sync && cur_valid;
        miss_sync   = bus.sync && !cur_valid;
        release_cur = accept_sync && (idx == LAST_IDX);
        last_frame  = accept_sync && (frames_left == SIZE_WIDTH'(1));
        issue       = (words_left != '0) && !bus.fifo_empty && !rd_en_q && !rd_valid
                      && (!cur_valid || !nxt_valid);
      end
      default: ;
    endcase
  end

  // Datapath: counters, word buffers, frame output and status flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      frames_left <= '0;
      words_left  <= '0;
      cur_word    <= '0;
      nxt_word    <= '0;
      cur_valid   <= 1'b0;
      nxt_valid   <= 1'b0;
      idx         <= '0;
      rd_valid    <= 1'b0;
      rd_en_q     <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      rd_en_q     <= issue;
      rd_valid    <= rd_en_q;
      out_valid_q <= accept_sync;
      done_q      <= zero_start || last_frame;
      if (accept_start) begin
        frames_left <= bus.frame_count;
        words_left  <= words_total - SIZE_WIDTH'(issue);
        underrun_q  <= 1'b0;
        idx         <= '0;
        cur_valid   <= 1'b0;
        nxt_valid   <= 1'b0;
      end else if (state == RUN) begin
        if (issue) words_left <= words_left - SIZE_WIDTH'(1);
        if (miss_sync) underrun_q <= 1'b1;
        if (accept_sync) begin
          out_q       <= frame_slice;
          frames_left <= frames_left - SIZE_WIDTH'(1);
        end
        if (release_cur) begin
          idx <= '0;
          if (nxt_valid) begin
            cur_word  <= nxt_word;
            cur_valid <= 1'b1;
            nxt_valid <= 1'b0;
          end else if (rd_valid) begin
            cur_word  <= bus.fifo_rd_data;
            cur_valid <= 1'b1;
          end else begin
            cur_valid <= 1'b0;
          end
        end else begin
          if (accept_sync) idx <= idx + IDX_W'(1);
          if (rd_valid) begin
            if (!cur_valid) begin
              cur_word  <= bus.fifo_rd_data;
              cur_valid <= 1'b1;
            end else begin
              nxt_word  <= bus.fifo_rd_data;
              nxt_valid <= 1'b1;
            end
          end
        end
        if (last_frame) begin
          cur_valid <= 1'b0;
          nxt_valid <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_switch_frame_sequencer.sv
// Directed bench for switch_frame_sequencer: a small FIFO model feeds words,
// each scenario task drives the run controls and checks outputs at negedge.
module tb_switch_frame_sequencer;
  localparam int DW = 128;
  localparam int NS = 7;
  localparam int SW = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  switch_frame_sequencer_if #(.DATA_WIDTH(DW), .NUM_SWITCHES(NS), .SIZE_WIDTH(SW)) bus();

  switch_frame_sequencer #(.DATA_WIDTH(DW), .NUM_SWITCHES(NS), .SIZE_WIDTH(SW)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  logic [DW-1:0] mem [0:15];
  logic [3:0]    wr_ptr = 4'd0;
  logic [3:0]    rd_ptr = 4'd0;
  logic          hold_empty = 1'b0;
  logic          flush = 1'b0;

  int passed = 0;
  int total = 0;
  int ov_cnt = 0;
  int done_cnt = 0;
  int rd_cnt = 0;

  // FIFO empty flag, optionally forced high to starve the sequencer.
  always_comb bus.fifo_empty = hold_empty || (wr_ptr == rd_ptr);

  // FIFO read port: data appears the cycle after a pop request.
  always @(posedge clock) begin
    if (flush) rd_ptr <= wr_ptr;
    else if (bus.fifo_rd_en && (wr_ptr != rd_ptr)) begin
      bus.fifo_rd_data <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 4'd1;
    end
  end

  task automatic tick();
    @(negedge clock);
    ov_cnt   += int'(bus.out_valid);
    done_cnt += int'(bus.done);
    rd_cnt   += int'(bus.fifo_rd_en);
  endtask

  task automatic clear_counts();
    ov_cnt = 0;
    done_cnt = 0;
    rd_cnt = 0;
  endtask

  task automatic push(input logic [DW-1:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 4'd1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  function automatic logic [DW-1:0] make_word(input int base, input logic [1:0] top);
    logic [DW-1:0] w;
    w = '0;
    for (int k = 0; k < 18; k++) w[k*NS +: NS] = 7'(base + k);
    w[127:126] = top;
    return w;
  endfunction

  task automatic start_run(input int count);
    bus.frame_count = 32'(count);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] outs;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.start = 1'($urandom_range(0, 1));
      bus.sync = 1'($urandom_range(0, 1));
      bus.frame_count = $urandom;
      hold_empty = 1'($urandom_range(0, 1));
      tick();
      outs = {bus.fifo_rd_en, bus.out_to_switches, bus.out_valid, bus.busy, bus.done, bus.underrun};
      total++;
      if (outs !== 12'd0) $display("FAIL reset_outputs cycle %0d: got %h expected 000", i, outs);
      else passed++;
    end
    bus.start = 1'b0;
    bus.sync = 1'b0;
    bus.frame_count = '0;
    hold_empty = 1'b0;
    reset = 1'b0;
    tick();
    total++;
    if (bus.busy !== 1'b0) $display("FAIL reset_release_busy: got %b expected 0", bus.busy);
    else passed++;
  endtask

  task automatic test_single_word();
    push(128'h80C101);
    clear_counts();
    start_run(4);
    total++;
    if ({bus.busy, bus.fifo_rd_en} !== 2'b11)
      $display("FAIL single_start: got busy=%b rd_en=%b expected 1 1", bus.busy, bus.fifo_rd_en);
    else passed++;
    tick();
    tick();
    bus.sync = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if ({bus.out_to_switches, bus.out_valid, bus.done, bus.busy} !== {7'(i + 1), 1'b1, (i == 3), (i != 3)})
        $display("FAIL single_frame%0d: got out=%0h valid=%b done=%b busy=%b expected out=%0h valid=1 done=%b busy=%b",
                 i, bus.out_to_switches, bus.out_valid, bus.done, bus.busy, i + 1, i == 3, i != 3);
      else passed++;
    end
    bus.sync = 1'b0;
    tick();
    total++;
    if (ov_cnt !== 4 || done_cnt !== 1 || rd_cnt !== 1 || bus.out_to_switches !== 7'd4)
      $display("FAIL single_totals: got valids=%0d dones=%0d pops=%0d out=%0h expected 4 1 1 4",
               ov_cnt, done_cnt, rd_cnt, bus.out_to_switches);
    else passed++;
  endtask

  task automatic test_word_boundary();
    logic [NS-1:0] exp;
    push(make_word(1, 2'b11));
    push(make_word(7'h40, 2'b00));
    clear_counts();
    start_run(20);
    tick();
    tick();
    bus.sync = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      exp = (i < 18) ? 7'(1 + i) : 7'(8'h40 + i - 18);
      total++;
      if (bus.out_to_switches !== exp || bus.out_valid !== 1'b1 || bus.done !== (i == 19))
        $display("FAIL boundary_frame%0d: got out=%0h valid=%b done=%b expected out=%0h valid=1 done=%b",
                 i, bus.out_to_switches, bus.out_valid, bus.done, exp, i == 19);
      else passed++;
    end
    bus.sync = 1'b0;
    tick();
    total++;
    if (rd_cnt !== 2 || bus.underrun !== 1'b0 || ov_cnt !== 20 || done_cnt !== 1)
      $display("FAIL boundary_totals: got pops=%0d underrun=%b valids=%0d dones=%0d expected 2 0 20 1",
               rd_cnt, bus.underrun, ov_cnt, done_cnt);
    else passed++;
  endtask

  task automatic test_underrun();
    reset = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    reset = 1'b0;
    hold_empty = 1'b1;
    clear_counts();
    start_run(2);
    bus.sync = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bus.sync = 1'b0;
    total++;
    if (bus.underrun !== 1'b1 || ov_cnt !== 0 || bus.out_to_switches !== 7'd0 || rd_cnt !== 0)
      $display("FAIL underrun_flag: got underrun=%b valids=%0d out=%0h pops=%0d expected 1 0 0 0",
               bus.underrun, ov_cnt, bus.out_to_switches, rd_cnt);
    else passed++;
    push(make_word(7'h2A, 2'b00));
    hold_empty = 1'b0;
    tick();
    tick();
    tick();
    bus.sync = 1'b1;
    tick();
    total++;
    if (bus.out_to_switches !== 7'h2A || bus.out_valid !== 1'b1 || bus.underrun !== 1'b1)
      $display("FAIL underrun_recover: got out=%0h valid=%b underrun=%b expected 2a 1 1",
               bus.out_to_switches, bus.out_valid, bus.underrun);
    else passed++;
    tick();
    bus.sync = 1'b0;
    total++;
    if (bus.out_to_switches !== 7'h2B || bus.done !== 1'b1)
      $display("FAIL underrun_finish: got out=%0h done=%b expected 2b 1", bus.out_to_switches, bus.done);
    else passed++;
    tick();
    total++;
    if (bus.underrun !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL underrun_sticky: got underrun=%b busy=%b expected 1 0", bus.underrun, bus.busy);
    else passed++;
  endtask

  task automatic test_zero_count();
    push(make_word(5, 2'b00));
    clear_counts();
    start_run(0);
    total++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.underrun !== 1'b0)
      $display("FAIL zero_done: got done=%b busy=%b underrun=%b expected 1 0 0", bus.done, bus.busy, bus.underrun);
    else passed++;
    tick();
    total++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || rd_cnt !== 0)
      $display("FAIL zero_after: got done=%b busy=%b pops=%0d expected 0 0 0", bus.done, bus.busy, rd_cnt);
    else passed++;
    do_flush();
  endtask

  task automatic test_control_corners();
    logic [11:0] outs;
    push(make_word(7'h10, 2'b00));
    clear_counts();
    start_run(3);
    tick();
    tick();
    bus.sync = 1'b1;
    tick();
    bus.sync = 1'b0;
    total++;
    if (bus.out_to_switches !== 7'h10)
      $display("FAIL corner_first: got out=%0h expected 10", bus.out_to_switches);
    else passed++;
    start_run(100);
    total++;
    if (bus.busy !== 1'b1) $display("FAIL corner_restart_busy: got %b expected 1", bus.busy);
    else passed++;
    bus.sync = 1'b1;
    tick();
    tick();
    bus.sync = 1'b0;
    total++;
    if (bus.out_to_switches !== 7'h12 || bus.done !== 1'b1)
      $display("FAIL corner_restart_ignored: got out=%0h done=%b expected 12 1", bus.out_to_switches, bus.done);
    else passed++;
    tick();
    total++;
    if (ov_cnt !== 3 || done_cnt !== 1 || rd_cnt !== 1 || bus.busy !== 1'b0)
      $display("FAIL corner_restart_totals: got valids=%0d dones=%0d pops=%0d busy=%b expected 3 1 1 0",
               ov_cnt, done_cnt, rd_cnt, bus.busy);
    else passed++;

    push(make_word(7'h20, 2'b00));
    clear_counts();
    start_run(5);
    tick();
    tick();
    bus.sync = 1'b1;
    tick();
    tick();
    bus.sync = 1'b0;
    reset = 1'b1;
    tick();
    outs = {bus.fifo_rd_en, bus.out_to_switches, bus.out_valid, bus.busy, bus.done, bus.underrun};
    total++;
    if (outs !== 12'd0) $display("FAIL corner_midrun_reset: got %h expected 000", outs);
    else passed++;
    reset = 1'b0;
    tick();
    do_flush();
    total++;
    if (done_cnt !== 0 || bus.busy !== 1'b0)
      $display("FAIL corner_reset_no_done: got dones=%0d busy=%b expected 0 0", done_cnt, bus.busy);
    else passed++;

    push(make_word(7'h30, 2'b00));
    clear_counts();
    start_run(2);
    tick();
    tick();
    bus.sync = 1'b1;
    tick();
    total++;
    if (bus.out_to_switches !== 7'h30 || bus.out_valid !== 1'b1)
      $display("FAIL corner_new_run_f0: got out=%0h valid=%b expected 30 1", bus.out_to_switches, bus.out_valid);
    else passed++;
    tick();
    bus.sync = 1'b0;
    total++;
    if (bus.out_to_switches !== 7'h31 || bus.done !== 1'b1)
      $display("FAIL corner_new_run_f1: got out=%0h done=%b expected 31 1", bus.out_to_switches, bus.done);
    else passed++;
    tick();
    total++;
    if (ov_cnt !== 2 || done_cnt !== 1 || rd_cnt !== 1)
      $display("FAIL corner_new_run_totals: got valids=%0d dones=%0d pops=%0d expected 2 1 1", ov_cnt, done_cnt, rd_cnt);
    else passed++;
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    bus.start = 1'b0;
    bus.sync = 1'b0;
    bus.frame_count = '0;
    test_reset();
    test_single_word();
    test_word_boundary();
    test_underrun();
    test_zero_count();
    test_control_corners();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Guard against a stuck simulation.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected completion before 200000");
    $fatal(1, "[TB] timeout");
  end
endmodule
